// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a single shared ALU.
// Optional {Z,N,C,V} response flags are enabled by defining ALU_ARB_FLAGS_EN.
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r0_req_valid,
    output logic         r0_req_ready,
    input  logic [4:0]   r0_ctrl,
    input  logic [N-1:0] r0_a,
    input  logic [N-1:0] r0_b,
    output logic         r0_rsp_valid,
    input  logic         r0_rsp_ready,
    input  logic         r1_req_valid,
    output logic         r1_req_ready,
    input  logic [4:0]   r1_ctrl,
    input  logic [N-1:0] r1_a,
    input  logic [N-1:0] r1_b,
    output logic         r1_rsp_valid,
    input  logic         r1_rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_err,
    output logic [4:0]   alu_ctrl,
    output logic [N-1:0] src_A,
    output logic [N-1:0] src_B,
`ifdef ALU_ARB_FLAGS_EN
    output logic [3:0]   rsp_flags,
`endif
    input  logic [N-1:0] alu_result
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Requesters hold valid/ctrl/a/b stable until ready; responses hold until rsp_ready.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [4:0]   ctrl_q, ctrl_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic         gid_q, gid_d;
    logic         ptr_q, ptr_d;
    logic [N-1:0] rsp_result_q, rsp_result_d;
    logic         rsp_err_q, rsp_err_d;
    logic         grant1;
    logic         op_ok;
    logic         rsp_hs;

    always_comb begin
        op_ok = 1'b0;
        case (ctrl_q) inside
            5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd10, 5'd11, 5'd12,
            5'd17, 5'd19, [5'd25:5'd30]: op_ok = 1'b1;
            default: op_ok = 1'b0;
        endcase
    end

    // Requester 1 wins when it is alone, or when both ask and the pointer names it.
    assign grant1 = r1_req_valid & (~r0_req_valid | ptr_q);
    assign rsp_hs = gid_q ? r1_rsp_ready : r0_rsp_ready;

`ifdef ALU_ARB_FLAGS_EN
    logic [3:0] flags_q, flags_d;
    logic       c_w, v_w;

    always_comb begin
        c_w = 1'b0;
        v_w = 1'b0;
        if (ctrl_q == 5'd1) begin
            c_w = (a_q + b_q) < a_q;
            v_w = ($signed(a_q) >= 0 && $signed(b_q) >= 0 && $signed(a_q + b_q) < 0) ||
                  ($signed(a_q) < 0 && $signed(b_q) < 0 && $signed(a_q + b_q) >= 0);
        end else if (ctrl_q == 5'd2) begin
            c_w = a_q >= b_q;
            v_w = ($signed(a_q) >= 0 && $signed(b_q) < 0 && $signed(a_q - b_q) < 0) ||
                  ($signed(a_q) < 0 && $signed(b_q) >= 0 && $signed(a_q - b_q) >= 0);
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (state_q == S_EXEC) begin
            flags_d = {(alu_result == '0), alu_result[N-1], c_w, v_w};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 4'd0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign rsp_flags = flags_q;
`endif

    always_comb begin
        state_d      = state_q;
        ctrl_d       = ctrl_q;
        a_d          = a_q;
        b_d          = b_q;
        gid_d        = gid_q;
        ptr_d        = ptr_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        r0_req_ready = 1'b0;
        r1_req_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (r0_req_valid | r1_req_valid) begin
                    r0_req_ready = ~grant1;
                    r1_req_ready = grant1;
                    ctrl_d       = grant1 ? r1_ctrl : r0_ctrl;
                    a_d          = grant1 ? r1_a : r0_a;
                    b_d          = grant1 ? r1_b : r0_b;
                    gid_d        = grant1;
                    if (r0_req_valid & r1_req_valid) begin
                        ptr_d = ~grant1;
                    end
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_result_d = alu_result;
                rsp_err_d    = ~op_ok;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_hs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ctrl_q       <= 5'd0;
            a_q          <= '0;
            b_q          <= '0;
            gid_q        <= 1'b0;
            ptr_q        <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            a_q          <= a_d;
            b_q          <= b_d;
            gid_q        <= gid_d;
            ptr_q        <= ptr_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_ctrl     = ctrl_q;
    assign src_A        = a_q;
    assign src_B        = b_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_err      = rsp_err_q;
    assign r0_rsp_valid = (state_q == S_RESP) & ~gid_q;
    assign r1_rsp_valid = (state_q == S_RESP) & gid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the ALU side.
// Define ALU_ARB_FLAGS_EN to also exercise the rsp_flags output.
module tb_alu_arbiter;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         r0_req_valid = 1'b0, r1_req_valid = 1'b0;
    logic         r0_req_ready, r1_req_ready;
    logic [4:0]   r0_ctrl = 5'd0, r1_ctrl = 5'd0;
    logic [N-1:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic         r0_rsp_valid, r1_rsp_valid;
    logic         r0_rsp_ready = 1'b0, r1_rsp_ready = 1'b0;
    logic [N-1:0] rsp_result;
    logic         rsp_err;
    logic [4:0]   alu_ctrl;
    logic [N-1:0] src_A, src_B;
    logic [N-1:0] alu_result;
`ifdef ALU_ARB_FLAGS_EN
    logic [3:0]   rsp_flags;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
        .r0_ctrl(r0_ctrl), .r0_a(r0_a), .r0_b(r0_b),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
        .r1_ctrl(r1_ctrl), .r1_a(r1_a), .r1_b(r1_b),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_ctrl(alu_ctrl), .src_A(src_A), .src_B(src_B),
`ifdef ALU_ARB_FLAGS_EN
        .rsp_flags(rsp_flags),
`endif
        .alu_result(alu_result)
    );

    // Shared ALU stand-in: unsupported opcodes return 0.
    always_comb begin
        case (alu_ctrl)
            5'd1:  alu_result = src_A + src_B;
            5'd2:  alu_result = src_A - src_B;
            5'd3:  alu_result = src_A * src_B;
            5'd9:  alu_result = src_A & src_B;
            5'd10: alu_result = src_A | src_B;
            5'd11: alu_result = src_A ^ src_B;
            5'd4, 5'd12, 5'd17, 5'd19, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30:
                   alu_result = src_A ^ src_B;
            default: alu_result = '0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total_cnt++;
        if ({r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid} !== 4'b0000)
            $display("FAIL reset_handshake: got %b want 0000",
                     {r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid});
        else pass_cnt++;
        total_cnt++;
        if ({rsp_result, rsp_err} !== '0)
            $display("FAIL reset_rsp: got %h/%b want 0/0", rsp_result, rsp_err);
        else pass_cnt++;
        total_cnt++;
        if ({alu_ctrl, src_A, src_B} !== '0)
            $display("FAIL reset_alu: got %h %h %h want 0", alu_ctrl, src_A, src_B);
        else pass_cnt++;
`ifdef ALU_ARB_FLAGS_EN
        total_cnt++;
        if (rsp_flags !== 4'd0) $display("FAIL reset_flags: got %b want 0000", rsp_flags);
        else pass_cnt++;
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        r0_rsp_ready = 1'b1;
        r1_rsp_ready = 1'b1;
        r0_ctrl = 5'd1; r0_a = 32'd5; r0_b = 32'd7; r0_req_valid = 1'b1;
        #1;
        total_cnt++;
        if ({r0_req_ready, r1_req_ready} !== 2'b10)
            $display("FAIL single_ready: got %b want 10", {r0_req_ready, r1_req_ready});
        else pass_cnt++;
        step();
        r0_req_valid = 1'b0;
        #1;
        total_cnt++;
        if ({alu_ctrl, src_A, src_B} !== {5'd1, 32'd5, 32'd7})
            $display("FAIL single_alu_drive: got %0d %0d %0d want 1 5 7", alu_ctrl, src_A, src_B);
        else pass_cnt++;
        total_cnt++;
        if ({r0_req_ready, r0_rsp_valid} !== 2'b00)
            $display("FAIL single_exec_quiet: got %b want 00", {r0_req_ready, r0_rsp_valid});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({r0_rsp_valid, r1_rsp_valid, rsp_result, rsp_err} !== {2'b10, 32'd12, 1'b0})
            $display("FAIL single_rsp: got v=%b%b res=%0d err=%b want v=10 res=12 err=0",
                     r0_rsp_valid, r1_rsp_valid, rsp_result, rsp_err);
        else pass_cnt++;
        step();
        total_cnt++;
        if (r0_rsp_valid !== 1'b0) $display("FAIL single_rsp_drop: got %b want 0", r0_rsp_valid);
        else pass_cnt++;
    endtask

    task automatic test_contention();
        r0_ctrl = 5'd2; r0_a = 32'd10; r0_b = 32'd3; r0_req_valid = 1'b1;
        r1_ctrl = 5'd9; r1_a = 32'hF0; r1_b = 32'h3C; r1_req_valid = 1'b1;
        #1;
        total_cnt++;
        if ({r0_req_ready, r1_req_ready} !== 2'b10)
            $display("FAIL cont_first_grant: got %b want 10", {r0_req_ready, r1_req_ready});
        else pass_cnt++;
        step();
        // r0 immediately queues a second request and keeps it asserted
        r0_ctrl = 5'd1; r0_a = 32'd1; r0_b = 32'd1;
        step();
        total_cnt++;
        if ({r0_rsp_valid, rsp_result, r1_req_ready} !== {1'b1, 32'd7, 1'b0})
            $display("FAIL cont_r0_rsp: got v=%b res=%0d r1rdy=%b want 1 7 0",
                     r0_rsp_valid, rsp_result, r1_req_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({r0_req_ready, r1_req_ready} !== 2'b01)
            $display("FAIL cont_second_grant: got %b want 01", {r0_req_ready, r1_req_ready});
        else pass_cnt++;
        step();
        r1_req_valid = 1'b0;
        step();
        total_cnt++;
        if ({r1_rsp_valid, r0_rsp_valid, rsp_result} !== {2'b10, 32'h30})
            $display("FAIL cont_r1_rsp: got v=%b%b res=%h want 10 30",
                     r1_rsp_valid, r0_rsp_valid, rsp_result);
        else pass_cnt++;
        step();
        total_cnt++;
        if (r0_req_ready !== 1'b1) $display("FAIL cont_r0_again: got %b want 1", r0_req_ready);
        else pass_cnt++;
        step();
        r0_req_valid = 1'b0;
        step();
        total_cnt++;
        if (rsp_result !== 32'd2) $display("FAIL cont_r0_second_res: got %0d want 2", rsp_result);
        else pass_cnt++;
        step();
    endtask

    task automatic test_fairness();
        logic exp1;
        r0_ctrl = 5'd1; r0_a = 32'd100; r0_b = 32'd1; r0_req_valid = 1'b1;
        r1_ctrl = 5'd2; r1_a = 32'd100; r1_b = 32'd1; r1_req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp1 = i[0];
            #1;
            total_cnt++;
            if ({r0_req_ready, r1_req_ready} !== {~exp1, exp1})
                $display("FAIL fair_grant_%0d: got %b want %b", i,
                         {r0_req_ready, r1_req_ready}, {~exp1, exp1});
            else pass_cnt++;
            step();
            step();
            total_cnt++;
            if ({r1_rsp_valid, rsp_result} !== {exp1, (exp1 ? 32'd99 : 32'd101)})
                $display("FAIL fair_rsp_%0d: got v1=%b res=%0d want v1=%b res=%0d", i,
                         r1_rsp_valid, rsp_result, exp1, exp1 ? 99 : 101);
            else pass_cnt++;
            step();
        end
        r0_req_valid = 1'b0;
        r1_req_valid = 1'b0;
        step();
    endtask

    task automatic test_stall();
        r1_rsp_ready = 1'b0;
        r0_rsp_ready = 1'b1;
        r1_ctrl = 5'd3; r1_a = 32'd6; r1_b = 32'd7; r1_req_valid = 1'b1;
        #1;
        total_cnt++;
        if (r1_req_ready !== 1'b1) $display("FAIL stall_accept: got %b want 1", r1_req_ready);
        else pass_cnt++;
        step();
        r1_req_valid = 1'b0;
        r0_ctrl = 5'd1; r0_a = 32'd2; r0_b = 32'd2; r0_req_valid = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if ({r1_rsp_valid, rsp_result, r0_req_ready} !== {1'b1, 32'd42, 1'b0})
                $display("FAIL stall_hold_%0d: got v=%b res=%0d r0rdy=%b want 1 42 0", i,
                         r1_rsp_valid, rsp_result, r0_req_ready);
            else pass_cnt++;
            step();
        end
        r1_rsp_ready = 1'b1;
        #1;
        total_cnt++;
        if (r0_req_ready !== 1'b0) $display("FAIL stall_hs_cycle: got %b want 0", r0_req_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({r0_req_ready, r1_rsp_valid} !== 2'b10)
            $display("FAIL stall_next_grant: got %b want 10", {r0_req_ready, r1_rsp_valid});
        else pass_cnt++;
        step();
        r0_req_valid = 1'b0;
        step();
        total_cnt++;
        if ({r0_rsp_valid, rsp_result} !== {1'b1, 32'd4})
            $display("FAIL stall_r0_rsp: got v=%b res=%0d want 1 4", r0_rsp_valid, rsp_result);
        else pass_cnt++;
        step();
    endtask

    task automatic test_illegal();
        logic [4:0] ctrl_tab [8] = '{5'd5, 5'd24, 5'd25, 5'd30, 5'd31, 5'd18, 5'd17, 5'd0};
        logic       err_tab  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            r0_ctrl = ctrl_tab[i]; r0_a = 32'd1; r0_b = 32'd1; r0_req_valid = 1'b1;
            step();
            r0_req_valid = 1'b0;
            step();
            total_cnt++;
            if ({r0_rsp_valid, rsp_err} !== {1'b1, err_tab[i]})
                $display("FAIL illegal_err_op%0d: got v=%b err=%b want 1 %b", ctrl_tab[i],
                         r0_rsp_valid, rsp_err, err_tab[i]);
            else pass_cnt++;
            if (err_tab[i]) begin
                total_cnt++;
                if (rsp_result !== 32'd0)
                    $display("FAIL illegal_res_op%0d: got %h want 0", ctrl_tab[i], rsp_result);
                else pass_cnt++;
            end
            step();
        end
    endtask

    task automatic test_reset_exec();
        r0_ctrl = 5'd1; r0_a = 32'd5; r0_b = 32'd7; r0_req_valid = 1'b1;
        step();
        r0_req_valid = 1'b0;
        #1;
        rst = 1'b1;
        step();
        total_cnt++;
        if ({r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid, rsp_err} !== 5'd0)
            $display("FAIL rst_exec_ctl: got %b want 00000",
                     {r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid, rsp_err});
        else pass_cnt++;
        total_cnt++;
        if ({rsp_result, alu_ctrl, src_A, src_B} !== '0)
            $display("FAIL rst_exec_data: got %h %h %h %h want 0", rsp_result, alu_ctrl, src_A, src_B);
        else pass_cnt++;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if ({r0_rsp_valid, r1_rsp_valid} !== 2'b00)
                $display("FAIL rst_exec_no_rsp_%0d: got %b want 00", i, {r0_rsp_valid, r1_rsp_valid});
            else pass_cnt++;
        end
    endtask

`ifdef ALU_ARB_FLAGS_EN
    task automatic test_flags();
        r0_ctrl = 5'd1; r0_a = 32'h7FFF_FFFF; r0_b = 32'd1; r0_req_valid = 1'b1;
        step();
        r0_req_valid = 1'b0;
        step();
        total_cnt++;
        if ({rsp_flags, rsp_result} !== {4'b0101, 32'h8000_0000})
            $display("FAIL flags_add_ovf: got %b %h want 0101 80000000", rsp_flags, rsp_result);
        else pass_cnt++;
        step();
        r0_ctrl = 5'd2; r0_a = 32'd3; r0_b = 32'd3; r0_req_valid = 1'b1;
        step();
        r0_req_valid = 1'b0;
        step();
        total_cnt++;
        if (rsp_flags !== 4'b1010) $display("FAIL flags_sub_zero: got %b want 1010", rsp_flags);
        else pass_cnt++;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_stall();
        test_illegal();
        test_reset_exec();
`ifdef ALU_ARB_FLAGS_EN
        test_flags();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
